// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 test circuit: LFSR patterns out, MISR signature in,
// pass/fail against a golden signature once the run completes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; waiting for start, pi driven to zero
// SETTLE  | pattern applied, counting settle cycles
// CAPTURE | one cycle; po folded into MISR at the closing edge
// DONE    | run complete; signature and pass held until start/reset
module c17_bist_ctrl #(
  parameter int          NUM_PATTERNS  = 31,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  GOLDEN_SIG    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] pi,
  input  logic [1:0] po,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] pat_cnt
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] NUM_PAT     = 5'(NUM_PATTERNS);
  localparam logic [4:0] LFSR_SEED   = 5'b00001;
  localparam logic [7:0] MISR_POLY   = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] lfsr, lfsr_nxt;
  logic [7:0] misr, misr_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [3:0] settle_cnt, settle_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lfsr       <= LFSR_SEED;
      misr       <= 8'h00;
      cnt        <= 5'd0;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      misr       <= misr_nxt;
      cnt        <= cnt_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lfsr_nxt   = lfsr;
    misr_nxt   = misr;
    cnt_nxt    = cnt;
    settle_nxt = settle_cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt  = ST_SETTLE;
          lfsr_nxt   = LFSR_SEED;
          misr_nxt   = 8'h00;
          cnt_nxt    = 5'd0;
          settle_nxt = 4'd0;
        end
      end
      ST_SETTLE: begin
        settle_nxt = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // x^5+x^3+1 Fibonacci step and MISR fold of {N23,N22}
        lfsr_nxt   = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        misr_nxt   = {misr[6:0], 1'b0} ^ (misr[7] ? MISR_POLY : 8'h00) ^ {6'b0, po};
        cnt_nxt    = cnt + 5'd1;
        settle_nxt = 4'd0;
        state_nxt  = (cnt_nxt == NUM_PAT) ? ST_DONE : ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);
  assign pass      = done && (misr == GOLDEN_SIG);
  assign pi        = busy ? lfsr : 5'd0;
  assign signature = misr;
  assign pat_cnt   = cnt;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: four controller instances with different parameter
// sets, one driving a behavioural c17 model; expectations flow through a queue.
module tb_c17_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  // A: 6 patterns, settle 1, po tied 0
  logic       rst_a, start_a, busy_a, done_a, pass_a;
  logic [4:0] pi_a, cnt_a;
  logic [7:0] sig_a;
  logic [1:0] po_a;
  // B/C: 3 patterns, settle 1, po tied 01, golden 07 / 06
  logic       rst_bc, start_bc, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [4:0] pi_b, cnt_b, pi_c, cnt_c;
  logic [7:0] sig_b, sig_c;
  logic [1:0] po_bc;
  // D: defaults, po from c17 model
  logic       rst_d, start_d, busy_d, done_d, pass_d;
  logic [4:0] pi_d, cnt_d;
  logic [7:0] sig_d;
  logic [1:0] po_d;

  function automatic logic [1:0] c17_resp(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [1:0] p);
    return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, p};
  endfunction

  assign po_a  = 2'b00;
  assign po_bc = 2'b01;
  assign po_d  = c17_resp(pi_d);

  c17_bist_ctrl #(.NUM_PATTERNS(6), .SETTLE_CYCLES(1), .GOLDEN_SIG(8'h00)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .pi(pi_a), .po(po_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a));
  c17_bist_ctrl #(.NUM_PATTERNS(3), .SETTLE_CYCLES(1), .GOLDEN_SIG(8'h07)) dut_b (
    .clk(clk), .reset(rst_bc), .start(start_bc), .pi(pi_b), .po(po_bc), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b));
  c17_bist_ctrl #(.NUM_PATTERNS(3), .SETTLE_CYCLES(1), .GOLDEN_SIG(8'h06)) dut_c (
    .clk(clk), .reset(rst_bc), .start(start_bc), .pi(pi_c), .po(po_bc), .busy(busy_c),
    .done(done_c), .pass(pass_c), .signature(sig_c), .pat_cnt(cnt_c));
  c17_bist_ctrl dut_d (
    .clk(clk), .reset(rst_d), .start(start_d), .pi(pi_d), .po(po_d), .busy(busy_d),
    .done(done_d), .pass(pass_d), .signature(sig_d), .pat_cnt(cnt_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_bc = 1; rst_d = 1;
    start_a = 0; start_bc = 0; start_d = 0;
    tick(); tick();
    rst_a = 0; rst_bc = 0; rst_d = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({pi_a, busy_a, done_a, pass_a, sig_a, cnt_a} !== 21'd0) begin
        miscompares++;
        $display("FAIL reset_idle_a cyc %0d: got %h expected 0", i, {pi_a, busy_a, done_a, pass_a, sig_a, cnt_a});
      end
      vectors++;
      if ({pi_b, busy_b, done_b, pass_b, sig_b, cnt_b, pi_c, busy_c, done_c, pass_c, sig_c, cnt_c} !== 42'd0) begin
        miscompares++;
        $display("FAIL reset_idle_bc cyc %0d: got %h expected 0", i,
                 {pi_b, busy_b, done_b, pass_b, sig_b, cnt_b, pi_c, busy_c, done_c, pass_c, sig_c, cnt_c});
      end
      vectors++;
      if ({pi_d, busy_d, done_d, pass_d, sig_d, cnt_d} !== 21'd0) begin
        miscompares++;
        $display("FAIL reset_idle_d cyc %0d: got %h expected 0", i, {pi_d, busy_d, done_d, pass_d, sig_d, cnt_d});
      end
    end
  endtask

  task automatic test_lfsr_seq();
    logic [4:0] seq [6];
    logic [7:0] e;
    seq = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
    for (int k = 0; k < 6; k++) begin
      sb.push_back({3'b0, seq[k]});
      sb.push_back({3'b0, seq[k]});
    end
    start_a = 1; tick(); start_a = 0;
    for (int i = 0; i < 12; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({3'b0, pi_a} !== e || busy_a !== 1'b1 || done_a !== 1'b0) begin
        miscompares++;
        $display("FAIL lfsr_pi cyc %0d: got pi=%h busy=%b done=%b expected pi=%h busy=1 done=0", i, pi_a, busy_a, done_a, e);
      end
      tick();
    end
    vectors++;
    if ({done_a, pass_a, busy_a, pi_a, sig_a, cnt_a} !== {1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 5'd6}) begin
      miscompares++;
      $display("FAIL lfsr_done: got done=%b pass=%b busy=%b pi=%h sig=%h cnt=%0d expected 1 1 0 00 00 6",
               done_a, pass_a, busy_a, pi_a, sig_a, cnt_a);
    end
  endtask

  task automatic test_misr();
    logic [7:0] e;
    sb.push_back(8'h01); sb.push_back(8'h03); sb.push_back(8'h07);
    start_bc = 1; tick(); start_bc = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(); tick();
      e = sb.pop_front();
      vectors++;
      if (sig_b !== e || cnt_b !== 5'(k)) begin
        miscompares++;
        $display("FAIL misr_step %0d: got sig=%h cnt=%0d expected sig=%h cnt=%0d", k, sig_b, cnt_b, e, k);
      end
    end
    vectors++;
    if ({done_b, pass_b} !== 2'b11) begin
      miscompares++;
      $display("FAIL misr_pass_golden07: got done=%b pass=%b expected 1 1", done_b, pass_b);
    end
    vectors++;
    if ({done_c, pass_c, sig_c} !== {2'b10, 8'h07}) begin
      miscompares++;
      $display("FAIL misr_pass_golden06: got done=%b pass=%b sig=%h expected 1 0 07", done_c, pass_c, sig_c);
    end
  endtask

  task automatic test_full_run(input int pulse_at);
    logic [4:0] l;
    logic [7:0] m;
    logic [7:0] e;
    int cyc;
    l = 5'b00001; m = 8'h00;
    for (int k = 0; k < 31; k++) begin
      m = misr_step(m, c17_resp(l));
      l = {l[3:0], l[4] ^ l[2]};
    end
    sb.push_back(m);
    start_d = 1; tick(); start_d = 0;
    cyc = 0;
    while (!done_d && cyc < 200) begin
      if (cyc == pulse_at) start_d = 1;
      tick();
      start_d = 0;
      cyc++;
    end
    e = sb.pop_front();
    vectors++;
    if (cyc !== 93) begin
      miscompares++;
      $display("FAIL full_latency pulse %0d: got %0d cycles expected 93", pulse_at, cyc);
    end
    vectors++;
    if (sig_d !== e || cnt_d !== 5'd31 || pass_d !== (e == 8'h00)) begin
      miscompares++;
      $display("FAIL full_signature pulse %0d: got sig=%h cnt=%0d pass=%b expected sig=%h cnt=31 pass=%b",
               pulse_at, sig_d, cnt_d, pass_d, e, (e == 8'h00));
    end
  endtask

  task automatic test_mid_reset();
    start_d = 1; tick(); start_d = 0;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (busy_d !== 1'b1 || cnt_d === 5'd0) begin
      miscompares++;
      $display("FAIL midrun_live: got busy=%b cnt=%0d expected busy=1 cnt>0", busy_d, cnt_d);
    end
    rst_d = 1; start_d = 1; tick(); rst_d = 0; start_d = 0;
    vectors++;
    if ({pi_d, busy_d, done_d, pass_d, sig_d, cnt_d} !== 21'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %h expected 0", {pi_d, busy_d, done_d, pass_d, sig_d, cnt_d});
    end
    tick();
    vectors++;
    if ({pi_d, busy_d} !== 6'd0) begin
      miscompares++;
      $display("FAIL midrun_reset_idle: got pi=%h busy=%b expected 00 0", pi_d, busy_d);
    end
    test_full_run(-1);
  endtask

  task automatic test_start_busy();
    test_full_run(4);
    start_d = 1; tick(); start_d = 0;
    vectors++;
    if ({pi_d, busy_d, done_d, sig_d, cnt_d} !== {5'h01, 1'b1, 1'b0, 8'h00, 5'd0}) begin
      miscompares++;
      $display("FAIL restart_from_done: got pi=%h busy=%b done=%b sig=%h cnt=%0d expected 01 1 0 00 0",
               pi_d, busy_d, done_d, sig_d, cnt_d);
    end
  endtask

  task automatic test_back_to_back();
    start_a = 1; tick();
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if ({done_a, cnt_a} !== {1'b1, 5'd6}) begin
      miscompares++;
      $display("FAIL b2b_first_done: got done=%b cnt=%0d expected 1 6", done_a, cnt_a);
    end
    tick();
    vectors++;
    if ({busy_a, done_a, pi_a, cnt_a, sig_a} !== {1'b1, 1'b0, 5'h01, 5'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%b done=%b pi=%h cnt=%0d sig=%h expected 1 0 01 0 00",
               busy_a, done_a, pi_a, cnt_a, sig_a);
    end
    start_a = 0;
    for (int i = 0; i < 11; i++) tick();
    vectors++;
    if ({done_a, busy_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_second_early: got done=%b busy=%b expected 0 1", done_a, busy_a);
    end
    tick();
    vectors++;
    if ({done_a, cnt_a, sig_a} !== {1'b1, 5'd6, 8'h00}) begin
      miscompares++;
      $display("FAIL b2b_second_done: got done=%b cnt=%0d sig=%h expected 1 6 00", done_a, cnt_a, sig_a);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_misr();
    test_full_run(-1);
    test_mid_reset();
    test_start_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
